// File: rtl/cpu_run_ctrl_if.sv
// Handshake/status bundle between the run controller and its host/core.
//   master: host side (drives requests, core status; observes ce/state/counters)
//   slave : cpu_run_ctrl side
// Signals:
//   run_req, halt_req, step_req, step_instr  run/step/halt requests (1-clk pulses)
//   div_load, div_value                      divider reload update
//   instr_done, cpu_pc                       core status
//   bkpt_addr, bkpt_valid                    breakpoint setup
//   cpu_ce, heartbeat, state, cycle_count, bkpt_hit   controller outputs
interface cpu_run_ctrl_if #(
  parameter int unsigned DIV_W = 26,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PC_W  = 16
);
  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic             step_instr;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             instr_done;
  logic [PC_W-1:0]  cpu_pc;
  logic [PC_W-1:0]  bkpt_addr;
  logic             bkpt_valid;
  logic             cpu_ce;
  logic             heartbeat;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_count;
  logic             bkpt_hit;

  modport master (
    output run_req, halt_req, step_req, step_instr, div_load, div_value,
           instr_done, cpu_pc, bkpt_addr, bkpt_valid,
    input  cpu_ce, heartbeat, state, cycle_count, bkpt_hit
  );

  modport slave (
    input  run_req, halt_req, step_req, step_instr, div_load, div_value,
           instr_done, cpu_pc, bkpt_addr, bkpt_valid,
    output cpu_ce, heartbeat, state, cycle_count, bkpt_hit
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the 16-bit multicycle core. A programmable tick
// divider gates single-cycle clock-enable pulses (cpu_ce) so the core stays in
// the system clock domain. Modes: free-run at the divided rate, single-cycle
// step, single-instruction step, halt. Also drives a 50%-duty LED heartbeat.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  cpu_run_ctrl_if.slave: requests, divider reload, core status in;
//        cpu_ce, heartbeat, state (0=HALT 1=RUN 2=STEP_CYC 3=STEP_INS),
//        cycle_count, bkpt_hit out
// Build option: define BKPT_EN to enable the PC breakpoint comparator; without
// it bkpt_hit is tied low and cpu_pc/bkpt_addr/bkpt_valid are ignored.
module cpu_run_ctrl #(
  parameter int unsigned     DIV_W       = 26,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(49999999),
  parameter int unsigned     CNT_W       = 32,
  parameter int unsigned     PC_W        = 16
) (
  input logic          clk,
  input logic          rst,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StHalt    = 2'd0,
    StRun     = 2'd1,
    StStepCyc = 2'd2,
    StStepIns = 2'd3
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_reg_q;
  logic             heartbeat_q;
  logic             cpu_ce_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic             tick;
  logic             bkpt_stop;
  logic [PC_W-1:0]  pc_diff;

  // A reload in progress suppresses the tick of that cycle.
  assign tick    = (div_cnt_q == div_reg_q) && !bus.div_load;
  assign pc_diff = bus.cpu_pc ^ bus.bkpt_addr;

`ifdef BKPT_EN
  logic bkpt_hit_q;

  // Only a retiring instruction (ce & instr_done) at the armed address stops the run.
  assign bkpt_stop = ((state_q == StRun) || (state_q == StStepIns)) && cpu_ce_q &&
                     bus.instr_done && bus.bkpt_valid && (pc_diff == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      bkpt_hit_q <= 1'b0;
    end else if (bus.halt_req) begin
      bkpt_hit_q <= bkpt_hit_q;
    end else if (bkpt_stop) begin
      bkpt_hit_q <= 1'b1;
    end else if ((state_q == StHalt) && (bus.run_req || bus.step_req)) begin
      bkpt_hit_q <= 1'b0;
    end
  end

  assign bus.bkpt_hit = bkpt_hit_q;
`else
  logic unused_bkpt;

  assign unused_bkpt  = ^{pc_diff, bus.bkpt_valid};
  assign bkpt_stop    = 1'b0;
  assign bus.bkpt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHalt;
      div_cnt_q     <= '0;
      div_reg_q     <= DEFAULT_DIV;
      heartbeat_q   <= 1'b0;
      cpu_ce_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      // Divider runs in every state.
      if (bus.div_load) begin
        div_reg_q <= bus.div_value;
        div_cnt_q <= '0;
      end else if (tick) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end

      if (tick) heartbeat_q <= ~heartbeat_q;

      // Counter advances on the same edge that raises cpu_ce.
      cpu_ce_q <= tick && (state_q != StHalt);
      if (tick && (state_q != StHalt)) cycle_count_q <= cycle_count_q + 1'b1;

      if (bus.halt_req || bkpt_stop) begin
        state_q <= StHalt;
      end else begin
        unique case (state_q)
          StHalt: begin
            if (bus.run_req) begin
              state_q <= StRun;
            end else if (bus.step_req) begin
              state_q <= bus.step_instr ? StStepIns : StStepCyc;
            end
          end
          StRun: state_q <= StRun;
          StStepCyc: begin
            // The tick seen here yields exactly one ce on the next clk.
            if (tick) state_q <= StHalt;
          end
          StStepIns: begin
            if (cpu_ce_q && bus.instr_done) state_q <= StHalt;
          end
        endcase
      end
    end
  end

  assign bus.cpu_ce      = cpu_ce_q;
  assign bus.heartbeat   = heartbeat_q;
  assign bus.state       = state_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios followed by random requests, every
// cycle compared against a behavioural model of the run controller.
module tb_cpu_run_ctrl;
  localparam int unsigned DEF_DIV = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.DIV_W(26), .CNT_W(32), .PC_W(16)) bus ();

  cpu_run_ctrl #(
    .DIV_W      (26),
    .DEFAULT_DIV(26'(DEF_DIV)),
    .CNT_W      (32),
    .PC_W       (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: state as the documented number, divider as plain integers.
  int          m_state;
  int unsigned m_dcnt;
  int unsigned m_dreg;
  bit          m_ce;
  bit          m_hb;
  bit          m_hit;
  logic [31:0] m_cc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate the model on the current inputs, advance one clock, compare.
  task automatic cyc();
    bit tick, bp, n_ce, n_hb, n_hit;
    int ns;
    int unsigned n_dcnt, n_dreg;
    logic [31:0] n_cc;
    if (rst) begin
      ns = 0; n_ce = 0; n_hb = 0; n_hit = 0; n_cc = 0; n_dcnt = 0; n_dreg = DEF_DIV;
    end else begin
      tick   = (m_dcnt == m_dreg) && !bus.div_load;
      n_ce   = tick && (m_state != 0);
      n_cc   = m_cc + 32'(n_ce);
      n_hb   = m_hb ^ tick;
      n_dreg = bus.div_load ? int'(bus.div_value) : m_dreg;
      n_dcnt = (bus.div_load || tick) ? 0 : m_dcnt + 1;
      ns     = m_state;
      n_hit  = m_hit;
`ifdef BKPT_EN
      bp = (m_state == 1 || m_state == 3) && m_ce && bus.instr_done && bus.bkpt_valid &&
           (bus.cpu_pc == bus.bkpt_addr);
`else
      bp = 0;
`endif
      if (bus.halt_req) ns = 0;
      else if (bp) begin ns = 0; n_hit = 1; end
      else if (m_state == 0 && bus.run_req) begin ns = 1; n_hit = 0; end
      else if (m_state == 0 && bus.step_req) begin ns = bus.step_instr ? 3 : 2; n_hit = 0; end
      else if (m_state == 2 && tick) ns = 0;
      else if (m_state == 3 && m_ce && bus.instr_done) ns = 0;
    end
    @(posedge clk);
    #1;
    m_state = ns; m_ce = n_ce; m_hb = n_hb; m_hit = n_hit; m_cc = n_cc;
    m_dcnt = n_dcnt; m_dreg = n_dreg;
    rst = 1'b0;
    bus.run_req = 1'b0; bus.halt_req = 1'b0; bus.step_req = 1'b0; bus.div_load = 1'b0;
    check("state", 64'(bus.state), 64'(m_state));
    check("cpu_ce", 64'(bus.cpu_ce), 64'(m_ce));
    check("heartbeat", 64'(bus.heartbeat), 64'(m_hb));
    check("cycle_count", 64'(bus.cycle_count), 64'(m_cc));
    check("bkpt_hit", 64'(bus.bkpt_hit), 64'(m_hit));
  endtask

  initial begin
    int pulses;
    int k;
    bus.run_req = 0; bus.halt_req = 0; bus.step_req = 0; bus.step_instr = 0;
    bus.div_load = 0; bus.div_value = '0; bus.instr_done = 0;
    bus.cpu_pc = '0; bus.bkpt_addr = '0; bus.bkpt_valid = 0;

    // T1: reset, then 20 idle clocks in HALT with the heartbeat running.
    rst = 1'b1; cyc();
    rst = 1'b1; cyc();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin cyc(); if (bus.cpu_ce) pulses++; end
    check("t1_no_ce", 64'(pulses), 64'd0);

    // T2: free-run until five pulses, then halt.
    bus.run_req = 1'b1; cyc();
    pulses = 0;
    for (int i = 0; i < 40 && pulses < 5; i++) begin cyc(); if (bus.cpu_ce) pulses++; end
    check("t2_pulses", 64'(pulses), 64'd5);
    check("t2_count", 64'(bus.cycle_count), 64'd5);
    bus.halt_req = 1'b1; cyc();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin cyc(); if (bus.cpu_ce) pulses++; end
    check("t2_halted_ce", 64'(pulses), 64'd0);

    // T3: single-cycle step.
    bus.step_req = 1'b1; bus.step_instr = 1'b0; cyc();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (bus.cpu_ce) pulses++; end
    check("t3_one_ce", 64'(pulses), 64'd1);
    check("t3_state", 64'(bus.state), 64'd0);
    check("t3_count", 64'(bus.cycle_count), 64'd6);

    // T4: instruction step, core finishes on its third enable.
    bus.step_req = 1'b1; bus.step_instr = 1'b1; cyc();
    k = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.cpu_ce) begin k++; bus.instr_done = (k == 3); end
      else bus.instr_done = 1'b0;
    end
    check("t4_three_ce", 64'(k), 64'd3);
    check("t4_state", 64'(bus.state), 64'd0);
    check("t4_count", 64'(bus.cycle_count), 64'd9);

    // T5: reload divider to 0 while running, then reset mid-run.
    bus.run_req = 1'b1; cyc();
    for (int i = 0; i < 5; i++) cyc();
    bus.div_load = 1'b1; bus.div_value = '0; cyc();
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin cyc(); check("t5_ce_every_clk", 64'(bus.cpu_ce), 64'd1); end
    rst = 1'b1; cyc();
    check("t5_rst_state", 64'(bus.state), 64'd0);
    check("t5_rst_ce", 64'(bus.cpu_ce), 64'd0);

`ifdef BKPT_EN
    // T6: breakpoint at 0x0010 during a run of one-clk instructions.
    bus.div_load = 1'b1; bus.div_value = '0; cyc();
    bus.bkpt_addr = 16'h0010; bus.bkpt_valid = 1'b1; bus.instr_done = 1'b1;
    bus.cpu_pc = 16'h000c; k = 0;
    bus.run_req = 1'b1; cyc();
    for (int i = 0; i < 60 && m_state != 0; i++) begin
      cyc();
      if (bus.cpu_ce) begin bus.cpu_pc = 16'(16'h000c + k); k++; end
    end
    check("t6_state", 64'(bus.state), 64'd0);
    check("t6_hit", 64'(bus.bkpt_hit), 64'd1);
    bus.instr_done = 1'b0; bus.bkpt_valid = 1'b0;
    bus.step_req = 1'b1; bus.step_instr = 1'b0; cyc();
    check("t6_hit_clear", 64'(bus.bkpt_hit), 64'd0);
`endif

    // Random requests, reloads, core status and occasional resets.
    for (int i = 0; i < 600; i++) begin
      bus.run_req    = ($urandom_range(0, 7) == 0);
      bus.halt_req   = ($urandom_range(0, 15) == 0);
      bus.step_req   = ($urandom_range(0, 7) == 0);
      bus.step_instr = 1'($urandom_range(0, 1));
      bus.div_load   = ($urandom_range(0, 31) == 0);
      bus.div_value  = 26'($urandom_range(0, 4));
      bus.instr_done = 1'($urandom_range(0, 1));
      bus.bkpt_valid = 1'($urandom_range(0, 1));
      bus.bkpt_addr  = 16'h0010;
      bus.cpu_pc     = ($urandom_range(0, 2) == 0) ? 16'h0010 : 16'($urandom_range(0, 31));
      rst            = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
